reg_file_param: RTL and testbench

Parametrised MIPS general-purpose register file with a per-register pending-write scoreboard and a sequenced bulk-clear engine. Successor to the fixed 32×32 register file; sits between the decode stage (read ports, scoreboard set) and the write-back stage (write port) of the MIPS datapath. Register 0 is hardwired to zero.

---
 rtl/reg_file_param.sv | 145 ++++++++++++++
 tb/tb_reg_file_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_param
// Purpose  : Parametrised MIPS general-purpose register file with a
//            per-register pending-write scoreboard and a sequenced
//            bulk-clear engine. Register 0 is hardwired to zero.
// Ports    : clk                 - clock, rising-edge active
//            reset               - asynchronous active-low reset
//            ra1/ra2 -> rd1/rd2  - combinational read ports
//            busy1/busy2         - pending bit of ra1/ra2, combinational
//            we/wa/wd            - write-back write port
//            sb_set/sb_addr      - mark a register as pending
//            clr_req             - start bulk clear; clr_busy high during it
// Config   : REGFILE_BYPASS_EN - forward the write port to the read ports
//            and the busy flags within the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_param #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              busy1,
  output logic              busy2,
  input  logic              clr_req,
  output logic              clr_busy
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = '0;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [DEPTH-1:0]   pend_q, pend_d;
  logic [WIDTH-1:0]   regs_q [DEPTH];

  // Single physical write port shared between the write-back path (IDLE)
  // and the sweep engine (SWEEP).
  logic               port_we;
  logic [ADDR_W-1:0]  port_addr;
  logic [WIDTH-1:0]   port_data;

  logic               wr_ok;   // architectural write accepted this cycle
  logic               sb_ok;   // scoreboard set accepted this cycle

  assign wr_ok = (state_q == S_IDLE) && we     && (wa != ZERO_IDX);
  assign sb_ok = (state_q == S_IDLE) && sb_set && (sb_addr != ZERO_IDX);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    port_we   = 1'b0;
    port_addr = wa;
    port_data = wd;

    case (state_q)
      S_IDLE: begin
        port_we = wr_ok;
        if (clr_req) begin
          // Clear request overrides any scoreboard activity on this edge.
          pend_d  = '0;
          idx_d   = ADDR_W'(1);
          state_d = S_SWEEP;
        end else begin
          if (wr_ok) pend_d[wa] = 1'b0;
          // Set is applied after the write clear so a same-address set wins.
          if (sb_ok) pend_d[sb_addr] = 1'b1;
        end
      end
      S_SWEEP: begin
        port_we   = 1'b1;
        port_addr = idx_q;
        port_data = '0;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      if (port_we) begin
        regs_q[port_addr] <= port_data;
      end
    end
  end

  assign clr_busy = (state_q == S_SWEEP);

  // Pending bits are hidden during a sweep: they were all cleared on entry
  // and no producer can be issued until the sweep finishes.
  always_comb begin
    rd1   = (ra1 == ZERO_IDX) ? '0 : regs_q[ra1];
    rd2   = (ra2 == ZERO_IDX) ? '0 : regs_q[ra2];
    busy1 = (state_q == S_IDLE) && pend_q[ra1];
    busy2 = (state_q == S_IDLE) && pend_q[ra2];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (wa == ra1)) begin
      rd1 = wd;
      if (!(sb_ok && (sb_addr == ra1))) busy1 = 1'b0;
    end
    if (wr_ok && (wa == ra2)) begin
      rd2 = wd;
      if (!(sb_ok && (sb_addr == ra2))) busy2 = 1'b0;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_param
// Purpose  : Directed self-checking bench for reg_file_param (32x32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_param;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] ra1, ra2, wa, sb_addr;
  logic [WIDTH-1:0]  rd1, rd2, wd;
  logic              we, sb_set, clr_req;
  logic              busy1, busy2, clr_busy;

  int n_tests;
  int n_fail;
  int cnt;

  reg_file_param #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ra1     (ra1),
    .ra2     (ra2),
    .rd1     (rd1),
    .rd2     (rd2),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .busy1   (busy1),
    .busy2   (busy2),
    .clr_req (clr_req),
    .clr_busy(clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    ra1 = '0; ra2 = '0; wa = '0; sb_addr = '0;
    wd = '0; we = 1'b0; sb_set = 1'b0; clr_req = 1'b0;

    // ---- reset state ----
    #2;
    chk("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
    #10 reset = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = ADDR_W'(i);
      ra2 = ADDR_W'(DEPTH - 1 - i);
      #1;
      chk("rst_rd1", rd1, 32'd0);
      chk("rst_rd2", rd2, 32'd0);
      chk("rst_busy", {30'd0, busy1, busy2}, 32'd0);
    end

    // ---- basic writes ----
    we = 1'b1; wa = 5'd5; wd = 32'h3;
    tick();
    wa = 5'd1; wd = 32'h5;
    tick();
    we = 1'b0; ra1 = 5'd5; ra2 = 5'd1;
    #1;
    chk("wr_reg5", rd1, 32'h3);
    chk("wr_reg1", rd2, 32'h5);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
    tick();
    we = 1'b0; ra1 = 5'd0;
    #1;
    chk("wr_reg0_ignored", rd1, 32'd0);

    // ---- scoreboard ----
    ra1 = 5'd7; ra2 = 5'd0;
    sb_set = 1'b1; sb_addr = 5'd7;
    #1;
    chk("sb_not_yet", {31'd0, busy1}, 32'd0);
    tick();
    sb_set = 1'b1; sb_addr = 5'd0;
    #1;
    chk("sb_busy1", {31'd0, busy1}, 32'd1);
    tick();
    sb_set = 1'b0;
    chk("sb_reg0_never", {31'd0, busy2}, 32'd0);
    we = 1'b1; wa = 5'd7; wd = 32'h1234;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("wr_busy_same_cycle", {31'd0, busy1}, 32'd0);
`else
    chk("wr_busy_same_cycle", {31'd0, busy1}, 32'd1);
`endif
    tick();
    we = 1'b0;
    #1;
    chk("wr_clears_busy", {31'd0, busy1}, 32'd0);
    chk("wr_reg7", rd1, 32'h1234);
    we = 1'b1; wa = 5'd7; wd = 32'h5678;
    sb_set = 1'b1; sb_addr = 5'd7;
    tick();
    we = 1'b0; sb_set = 1'b0;
    #1;
    chk("set_wins_busy", {31'd0, busy1}, 32'd1);
    chk("set_wins_data", rd1, 32'h5678);

    // ---- same-cycle visibility ----
    ra2 = 5'd9;
    we = 1'b1; wa = 5'd9; wd = 32'hA5A5_A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_rd2", rd2, 32'hA5A5_A5A5);
`else
    chk("nobypass_rd2", rd2, 32'd0);
`endif
    tick();
    we = 1'b0;
    #1;
    chk("wr_reg9", rd2, 32'hA5A5_A5A5);

    // ---- bulk clear ----
    for (int i = 1; i < DEPTH; i++) begin
      we = 1'b1; wa = ADDR_W'(i); wd = 32'(i);
      tick();
    end
    we = 1'b0;
    sb_set = 1'b1; sb_addr = 5'd4;
    tick();
    sb_set = 1'b0;
    ra1 = 5'd4; ra2 = 5'd20;
    #1;
    chk("fill_reg20", rd2, 32'd20);
    chk("pre_clr_busy4", {31'd0, busy1}, 32'd1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    chk("sweep_read_old", rd2, 32'd20);
    chk("sweep_busy_hidden", {31'd0, busy1}, 32'd0);
    while (clr_busy && cnt < 100) begin
      we = (cnt == 10); wa = 5'd3; wd = 32'hDEAD;
      sb_set = (cnt == 12); sb_addr = 5'd5;
      clr_req = (cnt == 14);
      tick();
      cnt++;
    end
    we = 1'b0; sb_set = 1'b0; clr_req = 1'b0;
    chk("sweep_len", 32'(cnt), 32'd31);
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = ADDR_W'(i);
      #1;
      chk("post_clr_rd", rd1, 32'd0);
      chk("post_clr_busy", {31'd0, busy1}, 32'd0);
    end
    chk("post_clr_idle", {31'd0, clr_busy}, 32'd0);
    we = 1'b1; wa = 5'd3; wd = 32'h77;
    tick();
    we = 1'b0; ra1 = 5'd3;
    #1;
    chk("first_write_after", rd1, 32'h77);

    // ---- reset in the middle of a sweep ----
    we = 1'b1; wa = 5'd30; wd = 32'd30;
    tick();
    we = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    ra1 = 5'd30;
    #1;
    chk("mid_sweep_busy", {31'd0, clr_busy}, 32'd1);
    chk("mid_sweep_reg30", rd1, 32'd30);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_clr_busy", {31'd0, clr_busy}, 32'd0);
    chk("rst_mid_reg30", rd1, 32'd0);
    #3 reset = 1'b1;
    tick();
    chk("rst_no_residual", {31'd0, clr_busy}, 32'd0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    while (clr_busy && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("resweep_len", 32'(cnt), 32'd31);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
